// File: rtl/cpu6502_pkg.sv
// Shared 6502 constants: sequencer states, addressing modes,
// ALU operation codes and the one illegal group-one opcode.
package cpu6502_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_FETCH_LO  = 3'd1;
    localparam state_t S_FETCH_HI  = 3'd2;
    localparam state_t S_PTR_LO    = 3'd3;
    localparam state_t S_PTR_HI    = 3'd4;
    localparam state_t S_READ_OPND = 3'd5;
    localparam state_t S_DONE      = 3'd6;

    typedef logic [2:0] mode_t;

    localparam mode_t M_IZX = 3'b000;
    localparam mode_t M_ZP  = 3'b001;
    localparam mode_t M_IMM = 3'b010;
    localparam mode_t M_ABS = 3'b011;
    localparam mode_t M_IZY = 3'b100;
    localparam mode_t M_ZPX = 3'b101;
    localparam mode_t M_ABY = 3'b110;
    localparam mode_t M_ABX = 3'b111;

    typedef logic [4:0] aluop_t;

    localparam aluop_t OP_ORA = 5'b00001;
    localparam aluop_t OP_AND = 5'b00101;
    localparam aluop_t OP_EOR = 5'b01001;
    localparam aluop_t OP_ADC = 5'b01101;
    localparam aluop_t OP_STA = 5'b10001;
    localparam aluop_t OP_LDA = 5'b10101;
    localparam aluop_t OP_CMP = 5'b11001;
    localparam aluop_t OP_SBC = 5'b11101;

    localparam logic [7:0] ILLEGAL_OP = 8'h89;

    function automatic logic is_abs(input mode_t m);
        return (m == M_ABS) || (m == M_ABX) || (m == M_ABY);
    endfunction

endpackage

// File: rtl/cpu6502_ea_adder.sv
// Effective-address adder: base + index, optionally
// confined to page zero.
module cpu6502_ea_adder (
    input  logic [15:0] base,
    input  logic [7:0]  idx,
    input  logic        zpw,
    output logic [15:0] sum
);

    logic [7:0] zsum;

    assign zsum = base[7:0] + idx;
    assign sum  = zpw ? {8'h00, zsum}
                      : base + {8'h00, idx};

endmodule

// File: rtl/cpu6502_operand_fetch.sv
// Group-one addressing-mode sequencer: resolves the
// effective address and fetches the ALU operand byte.
module cpu6502_operand_fetch
    import cpu6502_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  opcode,
    input  logic [15:0] pc,
    input  logic [7:0]  x_reg,
    input  logic [7:0]  y_reg,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic [4:0]  operation,
    output logic [7:0]  operand,
    output logic [15:0] eff_addr,
    output logic [15:0] pc_next,
    output logic        illegal
);

    state_t      state;
    mode_t       mode;
    logic [7:0]  xr;
    logic [7:0]  yr;
    logic [7:0]  lo;
    logic [15:0] pcr;
    logic [15:0] base;
    logic [15:0] sum;
    logic [7:0]  idx;
    logic        zpw;
    logic        sta;
    logic        res;

    assign sta = (operation == OP_STA);

    always_comb begin
        base = 16'h0000;
        idx  = 8'h00;
        zpw  = 1'b0;
        unique case (state)
            S_FETCH_LO: begin
                base = {8'h00, mem_rdata};
                zpw  = 1'b1;
                if (mode == M_ZPX || mode == M_IZX)
                    idx = xr;
            end
            S_FETCH_HI: begin
                base = {mem_rdata, lo};
                if (mode == M_ABX)
                    idx = xr;
                else if (mode == M_ABY)
                    idx = yr;
            end
            S_PTR_LO: begin
                base = mem_addr;
                idx  = 8'h01;
                zpw  = 1'b1;
            end
            S_PTR_HI: begin
                base = {mem_rdata, lo};
                if (mode == M_IZY)
                    idx = yr;
            end
            default: ;
        endcase
    end

    // Address fully known: go read the operand, or finish for STA.
    always_comb begin
        res = 1'b0;
        if (mem_ready) begin
            unique case (state)
                S_FETCH_LO: res = (mode == M_ZP) || (mode == M_ZPX);
                S_FETCH_HI: res = 1'b1;
                S_PTR_HI:   res = 1'b1;
                default:    res = 1'b0;
            endcase
        end
    end

    cpu6502_ea_adder u_ea (
        .base (base),
        .idx  (idx),
        .zpw  (zpw),
        .sum  (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mode      <= M_IZX;
            xr        <= 8'h00;
            yr        <= 8'h00;
            lo        <= 8'h00;
            pcr       <= 16'h0000;
            mem_addr  <= 16'h0000;
            mem_rd    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            operation <= 5'b00000;
            operand   <= 8'h00;
            eff_addr  <= 16'h0000;
            pc_next   <= 16'h0000;
            illegal   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: if (start) begin
                    mode      <= opcode[4:2];
                    xr        <= x_reg;
                    yr        <= y_reg;
                    pcr       <= pc;
                    operation <= {opcode[7:5], opcode[1:0]};
                    busy      <= 1'b1;
                    if (opcode[1:0] != 2'b01 || opcode == ILLEGAL_OP) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        illegal  <= 1'b1;
                        operand  <= 8'h00;
                        eff_addr <= 16'h0000;
                        pc_next  <= pc;
                    end else begin
                        state    <= S_FETCH_LO;
                        mem_rd   <= 1'b1;
                        mem_addr <= pc;
                        illegal  <= 1'b0;
                        pc_next  <= is_abs(opcode[4:2]) ? pc + 16'd2
                                                        : pc + 16'd1;
                    end
                end
                S_FETCH_LO: if (mem_ready) begin
                    unique case (mode)
                        M_IMM: begin
                            operand  <= mem_rdata;
                            eff_addr <= pcr;
                            mem_rd   <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end
                        M_ABS, M_ABX, M_ABY: begin
                            lo       <= mem_rdata;
                            mem_addr <= pcr + 16'd1;
                            state    <= S_FETCH_HI;
                        end
                        M_IZX, M_IZY: begin
                            mem_addr <= sum;
                            state    <= S_PTR_LO;
                        end
                        default: ;
                    endcase
                end
                S_PTR_LO: if (mem_ready) begin
                    lo       <= mem_rdata;
                    mem_addr <= sum;
                    state    <= S_PTR_HI;
                end
                S_READ_OPND: if (mem_ready) begin
                    operand <= mem_rdata;
                    mem_rd  <= 1'b0;
                    done    <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: ;
            endcase
            if (res) begin
                eff_addr <= sum;
                if (sta) begin
                    operand <= 8'h00;
                    mem_rd  <= 1'b0;
                    done    <= 1'b1;
                    state   <= S_DONE;
                end else begin
                    mem_addr <= sum;
                    state    <= S_READ_OPND;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu6502_operand_fetch.sv
// Directed bench for the operand-fetch sequencer with a
// byte memory model and programmable wait states.
module tb_cpu6502_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  opcode = 8'h00;
    logic [15:0] pc = 16'h0000;
    logic [7:0]  x_reg = 8'h00;
    logic [7:0]  y_reg = 8'h00;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic [4:0]  operation;
    logic [7:0]  operand;
    logic [15:0] eff_addr;
    logic [15:0] pc_next;
    logic        illegal;

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_log [$];
    int          nrd = 0;
    int          stall_idx = -1;
    int          stall_left = 0;
    int          stall_seen = 0;
    logic [15:0] wait_exp = 16'h0000;
    int          wait_bad = 0;
    int          rd_any = 0;
    int          total = 0;
    int          bad = 0;
    int          lat;
    int          ndone;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ready = !(mem_rd && nrd == stall_idx && stall_left > 0);

    always @(posedge clk) begin
        if (mem_rd)
            rd_any = 1;
        if (mem_rd && mem_ready) begin
            rd_log.push_back(mem_addr);
            nrd = nrd + 1;
        end else if (mem_rd) begin
            stall_left = stall_left - 1;
            stall_seen = stall_seen + 1;
            if (mem_addr != wait_exp)
                wait_bad = wait_bad + 1;
        end
    end

    cpu6502_operand_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .opcode    (opcode),
        .pc        (pc),
        .x_reg     (x_reg),
        .y_reg     (y_reg),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .operation (operation),
        .operand   (operand),
        .eff_addr  (eff_addr),
        .pc_next   (pc_next),
        .illegal   (illegal)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clr_log();
        rd_log.delete();
        nrd = 0;
        rd_any = 0;
        stall_seen = 0;
        wait_bad = 0;
    endtask

    // Start one instruction; lat = cycle of done after the start edge.
    task automatic run(input logic [7:0] opc, input logic [15:0] p,
                       input logic [7:0] x, input logic [7:0] y,
                       input bit poke, output int l);
        int cyc;
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        clr_log();
        opcode = opc;
        pc = p;
        x_reg = x;
        y_reg = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            if (poke && cyc == 2) begin
                start = 1'b1;
                opcode = 8'h09;
            end
            @(posedge clk);
            #1 start = 1'b0;
            cyc++;
        end
        l = done ? cyc : -1;
    endtask

    initial begin
        #12;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_outs", {operation, operand, illegal}, 0);
        chk("rst_addrs", {mem_addr, eff_addr}, 0);
        chk("rst_pcn", pc_next, 0);
        @(negedge clk);
        rst_n = 1'b1;

        mem[16'h0200] = 8'h42;
        run(8'hA9, 16'h0200, 8'h00, 8'h00, 0, lat);
        chk("imm_lat", lat, 2);
        chk("imm_opnd", operand, 8'h42);
        chk("imm_op", operation, 5'b10101);
        chk("imm_ea", eff_addr, 16'h0200);
        chk("imm_pcn", pc_next, 16'h0201);
        chk("imm_ill", illegal, 0);
        chk("imm_busy", busy, 1);
        chk("imm_nrd", nrd, 1);

        mem[16'h0200] = 8'hF0;
        mem[16'h0010] = 8'h7F;
        run(8'h75, 16'h0200, 8'h20, 8'h00, 0, lat);
        chk("zpx_lat", lat, 3);
        chk("zpx_nrd", nrd, 2);
        chk("zpx_rd1", rd_log[1], 16'h0010);
        chk("zpx_opnd", operand, 8'h7F);
        chk("zpx_ea", eff_addr, 16'h0010);
        chk("zpx_op", operation, 5'b01101);

        mem[16'h0200] = 8'hFF;
        mem[16'h00FF] = 8'hF8;
        mem[16'h0000] = 8'h12;
        mem[16'h1308] = 8'h5A;
        run(8'hB1, 16'h0200, 8'h00, 8'h10, 0, lat);
        chk("izy_lat", lat, 5);
        chk("izy_nrd", nrd, 4);
        chk("izy_rds", {rd_log[0], rd_log[1], rd_log[2], rd_log[3]},
            {16'h0200, 16'h00FF, 16'h0000, 16'h1308});
        chk("izy_opnd", operand, 8'h5A);
        chk("izy_ea", eff_addr, 16'h1308);
        chk("izy_pcn", pc_next, 16'h0201);

        mem[16'h0200] = 8'hF8;
        mem[16'h0201] = 8'hFF;
        mem[16'h0008] = 8'h33;
        stall_idx = 1;
        stall_left = 3;
        wait_exp = 16'h0201;
        run(8'hDD, 16'h0200, 8'h10, 8'h00, 0, lat);
        stall_idx = -1;
        chk("abx_lat", lat, 7);
        chk("abx_ea", eff_addr, 16'h0008);
        chk("abx_pcn", pc_next, 16'h0202);
        chk("abx_opnd", operand, 8'h33);
        chk("abx_stalls", stall_seen, 3);
        chk("abx_waitaddr", wait_bad, 0);

        mem[16'h0200] = 8'h34;
        mem[16'h0201] = 8'h12;
        mem[16'h1234] = 8'hEE;
        run(8'h8D, 16'h0200, 8'h00, 8'h00, 0, lat);
        chk("sta_lat", lat, 3);
        chk("sta_nrd", nrd, 2);
        chk("sta_ea", eff_addr, 16'h1234);
        chk("sta_opnd", operand, 8'h00);
        chk("sta_op", operation, 5'b10001);

        run(8'h89, 16'h0300, 8'h00, 8'h00, 0, lat);
        chk("ill_lat", lat, 1);
        chk("ill_flag", illegal, 1);
        chk("ill_rd", rd_any, 0);
        chk("ill_pcn", pc_next, 16'h0300);
        chk("ill_ea", eff_addr, 16'h0000);

        run(8'h02, 16'h0300, 8'h00, 8'h00, 0, lat);
        chk("ill2_lat", lat, 1);
        chk("ill2_flag", illegal, 1);

        // Absolute,Y wrapping past FFFF, with a start pulse mid-flight.
        mem[16'h0400] = 8'hF0;
        mem[16'h0401] = 8'hFF;
        mem[16'h0020] = 8'hC3;
        run(8'hB9, 16'h0400, 8'h00, 8'h30, 1, lat);
        chk("aby_lat", lat, 4);
        chk("aby_ea", eff_addr, 16'h0020);
        chk("aby_opnd", operand, 8'hC3);
        chk("aby_op", operation, 5'b10101);
        chk("aby_pcn", pc_next, 16'h0402);

        mem[16'h0200] = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        clr_log();
        opcode = 8'hB1;
        pc = 16'h0200;
        y_reg = 8'h10;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 20 && nrd < 2; i++) begin
            @(posedge clk);
            #1;
        end
        chk("abort_phi_rd", mem_rd, 1);
        chk("abort_phi_addr", mem_addr, 16'h0000);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rd", mem_rd, 0);
        chk("abort_busy", busy, 0);
        ndone = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done)
                ndone++;
        end
        chk("abort_nodone", ndone, 0);
        chk("abort_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu6502_operand_fetch.md
# cpu6502_operand_fetch

Addressing-mode sequencer for 6502 group-one instructions (opcode bits [1:0] = 01: ORA, AND, EOR, ADC, STA, LDA, CMP, SBC). It runs directly upstream of the 6502 ALU. Given a latched opcode, the operand-byte address and the X/Y index values, it issues byte reads on a simple memory port to resolve the effective address and the data operand. It then hands the ALU a 5-bit operation code and the operand byte, with a one-cycle done strobe.

## Interface
- No parameters; address width fixed at 16, data width at 8.
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin decode of opcode; sampled only while busy=0
- opcode  in  8  instruction byte, sampled with start
- pc  in  16  address of first operand byte, sampled with start
- x_reg, y_reg  in  8  index registers, sampled with start
- mem_addr  out  16  read address, valid while mem_rd=1
- mem_rd  out  1  read request, held until mem_ready
- mem_rdata  in  8  read data, valid in the cycle mem_rd and mem_ready are both high
- mem_ready  in  1  read completes this cycle
- busy  out  1  sequencer not idle
- done  out  1  one-cycle pulse; result outputs valid and held until next start
- operation  out  5  {opcode[7:5], opcode[1:0]}, ALU operation code
- operand  out  8  fetched data byte; 8'h00 for STA
- eff_addr  out  16  effective address; for immediate mode, address of the immediate byte
- pc_next  out  16  pc plus operand length, modulo 2^16
- illegal  out  1  valid with done; opcode not handled

## Operation
- Mode is opcode[4:2]:
  - 000 = (zp,X)
  - 001 = zp
  - 010 = #imm
  - 011 = abs
  - 100 = (zp),Y
  - 101 = zp,X
  - 110 = abs,Y
  - 111 = abs,X
- FSM states: IDLE, FETCH_LO, FETCH_HI, PTR_LO, PTR_HI, READ_OPND, DONE. Every state except IDLE and DONE issues one read and advances only on mem_ready.
- State sequence per mode:
  - #imm: FETCH_LO(pc). The byte becomes operand; eff_addr = pc.
  - zp: FETCH_LO(pc), then READ_OPND({8'h00, b}).
  - zp,X: as zp, with address {8'h00, (b+X) mod 256}.
  - abs: FETCH_LO(pc), FETCH_HI(pc+1), READ_OPND({hi,lo}).
  - abs,X / abs,Y: as abs, with address {hi,lo} + index, full 16-bit add, wrapping at FFFF.
  - (zp,X): FETCH_LO(pc); p = (b+X) mod 256; PTR_LO({00,p}); PTR_HI({00,(p+1) mod 256}); READ_OPND(pointer).
  - (zp),Y: FETCH_LO(pc); PTR_LO({00,b}); PTR_HI({00,(b+1) mod 256}); READ_OPND(pointer+Y), 16-bit, wrapping.
- STA (opcode[7:5]=100): READ_OPND is skipped. After address resolution the FSM goes to DONE with operand=8'h00.
- pc_next = pc+2 for abs modes and pc+1 for all others.
- Illegal opcodes are opcode[1:0]≠01 and STA #imm (8'h89). For these: no memory reads; next state DONE; illegal=1, operand=0, eff_addr=0, pc_next=pc.
- DONE always returns to IDLE on the following cycle.
- start while busy=1 is ignored; no queuing.

## Timing
- All outputs are registered.
- Reset values: mem_addr=0, mem_rd=0, busy=0, done=0, operation=0, operand=0, eff_addr=0, pc_next=0, illegal=0; state IDLE.
- Reset asserted mid-sequence: all outputs take their reset values immediately, including mem_rd=0. No done is produced for the aborted sequence.
- start accepted at edge E0. busy=1 and the first mem_rd are visible in the cycle after E0.
- With zero-wait memory, each read takes one cycle. done is asserted in the cycle after the final read completes.
- Latency from the start edge to the done-high cycle is (reads+1):
  - #imm: 2
  - zp, zp,X: 3
  - abs, abs,X/Y: 4
  - (zp,X), (zp),Y: 5
  - STA: one fewer than the corresponding read case
  - illegal: 1
- Each cycle with mem_ready=0 adds exactly one cycle. mem_addr and mem_rd stay stable throughout a wait.
- busy is high from the cycle after the start edge through the done cycle, inclusive.
- A new start is accepted in the first cycle after done, when busy=0.

## Structure
- Shared package cpu6502_pkg holds:
  - state encoding
  - addressing-mode constants (bbb codes)
  - the 5-bit ALU operation constants (ORA, AND, EOR, ADC, STA, LDA, CMP, SBC), shared with the ALU
  - the illegal-opcode constant 8'h89
- One sub-module: cpu6502_ea_adder, combinational. It adds a 16-bit base and an 8-bit index, with a zero-page-wrap select. It is used for zp,X, pointer+1, abs,X/Y and (zp),Y.

## Test plan
- LDA #$42 (A9), pc=0200, mem[0200]=42, zero-wait -> done in cycle 2; operand=42, operation=10101, eff_addr=0200, pc_next=0201.
- ADC $F0,X (75), X=20, mem[0200]=F0, mem[0010]=7F -> reads at 0200 then 0010 (zero-page wrap); operand=7F, eff_addr=0010, done in cycle 3.
- LDA ($FF),Y (B1), Y=10, mem[0200]=FF, mem[00FF]=F8, mem[0000]=12, mem[1308]=5A -> reads 0200, 00FF, 0000, 1308; operand=5A, done in cycle 5.
- CMP $FFF8,X (DD), X=10 -> eff_addr=0008, pc_next=0202. mem_ready held low 3 cycles during FETCH_HI -> done in cycle 7; mem_addr stays 0201 throughout the wait.
- STA $1234 (8D) -> exactly 2 reads (0200, 0201), none at 1234; eff_addr=1234, operand=00, done in cycle 3.
- Illegal/abort cases:
  - opcode 89 -> done in cycle 1, illegal=1, no mem_rd.
  - start pulsed while busy -> ignored.
  - rst_n low during PTR_HI -> mem_rd=0 immediately, no done pulse.
